// File: rtl/div_pkg.sv
// Shared types and helpers for the divider-ratio detector.
//   NUM_SEL      : number of legal divider selects (/2, /4, /8, /16)
//   err_code_e   : error classification reported alongside err
//   state_e      : measurement FSM states
//   exp_period() : expected period in clk cycles for a given select
package div_pkg;

    localparam int unsigned NUM_SEL = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_BAD_PERIOD = 2'd1,
        ERR_BAD_DUTY   = 2'd2,
        ERR_TIMEOUT    = 2'd3
    } err_code_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    // Period produced by divider select sel: 2 << sel.
    function automatic int unsigned exp_period(input logic [SEL_W-1:0] sel);
        return 32'd2 << sel;
    endfunction

endpackage

// File: rtl/div_ratio_detect_if.sv
// Bus between the divided waveform source and the ratio detector.
//   sig_in     : divided waveform under test (source -> detector)
//   sel_out    : recovered divider select
//   period_out : last measured period in clk cycles
//   meas_valid : one-cycle pulse when period_out/sel_out update
//   locked     : stable-select lock level
//   err        : one-cycle error pulse
//   err_code   : classification of the last error, cleared by a good measurement
// master = waveform source / observer, slave = detector.
interface div_ratio_detect_if
    import div_pkg::*;
#(
    parameter int unsigned CNT_W = 6
);

    logic             sig_in;
    logic [SEL_W-1:0] sel_out;
    logic [CNT_W-1:0] period_out;
    logic             meas_valid;
    logic             locked;
    logic             err;
    err_code_e        err_code;

    modport master (
        output sig_in,
        input  sel_out,
        input  period_out,
        input  meas_valid,
        input  locked,
        input  err,
        input  err_code
    );

    modport slave (
        input  sig_in,
        output sel_out,
        output period_out,
        output meas_valid,
        output locked,
        output err,
        output err_code
    );

endinterface

// File: rtl/sync_edge.sv
// Synchronizer plus edge detector for an asynchronous square wave.
//   clk, rst : clock and synchronous active-high reset
//   din      : raw asynchronous input
//   s        : synchronized level (last synchronizer flop)
//   rise     : s went 0 -> 1 this cycle (combinational from s and its delay)
//   fall     : s went 1 -> 0 this cycle (combinational from s and its delay)
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;

    // Synchronizer chain followed by one delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync[0] <= din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync[i] <= sync[i-1];
            end
            s_d <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/div_ratio_detect.sv
// Receive end of the power-of-two clock divider: measures period and high
// time of a divided square wave, recovers the divider select, and reports
// lock, malformed waveforms and loss of signal.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of div_ratio_detect_if (sig_in in, results out)
module div_ratio_detect
    import div_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned TIMEOUT     = 40,
    parameter int unsigned LOCK_CNT    = 4
) (
    input logic              clk,
    input logic              rst,
    div_ratio_detect_if.slave bus
);

    localparam int unsigned MATCH_W = 4;

    logic s;
    logic rise;
    logic fall;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sig_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    state_e             state;
    logic [CNT_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   hi_cnt;
    logic               hi_run;
    logic [MATCH_W-1:0] match;

    logic               p_legal;
    logic [SEL_W-1:0]   p_sel;
    logic               duty_ok;
    logic [MATCH_W-1:0] match_inc;

    // Classify the period currently held in per_cnt/hi_cnt.
    always_comb begin
        p_legal = 1'b0;
        p_sel   = '0;
        for (int i = 0; i < int'(NUM_SEL); i++) begin
            if (per_cnt == CNT_W'(exp_period(SEL_W'(i)))) begin
                p_legal = 1'b1;
                p_sel   = SEL_W'(i);
            end
        end
        duty_ok = (hi_cnt == (per_cnt >> 1));
    end

    // A previous non-good result always leaves match at 0, so comparing with
    // sel_out is equivalent to comparing with the previous good select.
    always_comb begin
        if (p_sel == bus.sel_out) begin
            match_inc = (match >= MATCH_W'(LOCK_CNT)) ? MATCH_W'(LOCK_CNT)
                                                      : match + MATCH_W'(1);
        end else begin
            match_inc = MATCH_W'(1);
        end
    end

    // Measurement FSM with registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            per_cnt        <= '0;
            hi_cnt         <= '0;
            hi_run         <= 1'b0;
            match          <= '0;
            bus.sel_out    <= '0;
            bus.period_out <= '0;
            bus.meas_valid <= 1'b0;
            bus.locked     <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_code   <= ERR_NONE;
        end else begin
            bus.meas_valid <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        per_cnt <= CNT_W'(1);
                        hi_cnt  <= CNT_W'(1);
                        hi_run  <= 1'b1;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        per_cnt        <= CNT_W'(1);
                        hi_cnt         <= CNT_W'(1);
                        hi_run         <= 1'b1;
                        bus.period_out <= per_cnt;
                        bus.meas_valid <= 1'b1;
                        if (p_legal) begin
                            bus.sel_out <= p_sel;
                            if (duty_ok) begin
                                bus.err_code <= ERR_NONE;
                                match        <= match_inc;
                                bus.locked   <= (match_inc >= MATCH_W'(LOCK_CNT));
                            end else begin
                                bus.err      <= 1'b1;
                                bus.err_code <= ERR_BAD_DUTY;
                                match        <= '0;
                                bus.locked   <= 1'b0;
                            end
                        end else begin
                            bus.err      <= 1'b1;
                            bus.err_code <= ERR_BAD_PERIOD;
                            match        <= '0;
                            bus.locked   <= 1'b0;
                        end
                    end else if (per_cnt == CNT_W'(TIMEOUT)) begin
                        // Loss of signal; stuck high or low both land here.
                        bus.err      <= 1'b1;
                        bus.err_code <= ERR_TIMEOUT;
                        match        <= '0;
                        bus.locked   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        // High time counts only the first high phase after rise.
                        if (fall) begin
                            hi_run <= 1'b0;
                        end else if (hi_run && s) begin
                            hi_cnt <= hi_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ratio_detect.sv
// Directed self-checking bench for div_ratio_detect (default parameters).
module tb_div_ratio_detect;
    import div_pkg::*;

    logic clk;
    logic rst;

    div_ratio_detect_if #(.CNT_W(6)) bus ();

    div_ratio_detect #(
        .SYNC_STAGES (2),
        .CNT_W       (6),
        .TIMEOUT     (40),
        .LOCK_CNT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int cyc;
    int mv_n;
    int mv_cyc;
    int err_n;
    int err_cyc;
    logic [31:0] mv_per;
    logic [31:0] mv_sel;
    logic [31:0] mv_err;
    logic [31:0] mv_code;
    logic [31:0] mv_lock;
    logic [31:0] err_seen_code;
    logic lock_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and capture any result pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.meas_valid === 1'b1) begin
            mv_n++;
            mv_cyc  = cyc;
            mv_per  = 32'(bus.period_out);
            mv_sel  = 32'(bus.sel_out);
            mv_err  = 32'(bus.err);
            mv_code = 32'(bus.err_code);
            mv_lock = 32'(bus.locked);
        end
        if (bus.err === 1'b1) begin
            err_n++;
            err_cyc       = cyc;
            err_seen_code = 32'(bus.err_code);
        end
        if (bus.locked === 1'b1) lock_seen = 1'b1;
    endtask

    task automatic wave(input int hi, input int lo);
        repeat (hi) begin bus.sig_in = 1'b1; tick(); end
        repeat (lo) begin bus.sig_in = 1'b0; tick(); end
    endtask

    task automatic clear_obs();
        mv_n = 0; mv_cyc = 0; err_n = 0; err_cyc = 0;
        mv_per = '0; mv_sel = '0; mv_err = '0; mv_code = '0; mv_lock = '0;
        err_seen_code = '0; lock_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sig_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},    32'(bus.sel_out),    32'd0);
        chk({tag, "_period"}, 32'(bus.period_out), 32'd0);
        chk({tag, "_mv"},     32'(bus.meas_valid), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked),     32'd0);
        chk({tag, "_err"},    32'(bus.err),        32'd0);
        chk({tag, "_code"},   32'(bus.err_code),   32'd0);
    endtask

    int w;
    int m0;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b1;
        bus.sig_in = 1'b0;
        clear_obs();

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Period 8, 4/4: first result 3 cycles after 2nd wave start, lock after 4 goods
        wave(4, 4);
        w = cyc;
        wave(4, 4);
        chk("p8_first_count", 32'(mv_n), 32'd1);
        chk("p8_first_cycle", 32'(mv_cyc), 32'(w + 3));
        chk("p8_sel", mv_sel, 32'd2);
        chk("p8_period", mv_per, 32'd8);
        wave(4, 4);
        wave(4, 4);
        chk("p8_count3", 32'(mv_n), 32'd3);
        chk("p8_unlocked_at3", 32'(bus.locked), 32'd0);
        wave(4, 4);
        chk("p8_count4", 32'(mv_n), 32'd4);
        chk("p8_locked_at4", 32'(bus.locked), 32'd1);
        wave(4, 4);
        chk("p8_no_err", 32'(err_n), 32'd0);
        chk("p8_code", 32'(bus.err_code), 32'd0);

        // Period 2 locks, then switch to period 16
        do_reset();
        repeat (6) wave(1, 1);
        wave(8, 8);
        chk("p2_count", 32'(mv_n), 32'd6);
        chk("p2_sel", mv_sel, 32'd0);
        chk("p2_period", mv_per, 32'd2);
        chk("p2_locked", 32'(bus.locked), 32'd1);
        wave(8, 8);
        chk("p16_sel", mv_sel, 32'd3);
        chk("p16_period", mv_per, 32'd16);
        chk("p16_lock_drop", mv_lock, 32'd0);
        wave(8, 8);
        wave(8, 8);
        chk("p16_unlocked_at3", 32'(bus.locked), 32'd0);
        wave(8, 8);
        chk("p16_locked_at4", 32'(bus.locked), 32'd1);
        chk("p16_no_err", 32'(err_n), 32'd0);

        // Period 6 after a period-8 measurement: bad period, sel unchanged
        do_reset();
        wave(4, 4);
        wave(4, 4);
        repeat (4) wave(3, 3);
        chk("p6_count", 32'(mv_n), 32'd5);
        chk("p6_err_count", 32'(err_n), 32'd3);
        chk("p6_err_with_mv", mv_err, 32'd1);
        chk("p6_code", mv_code, 32'd1);
        chk("p6_period", mv_per, 32'd6);
        chk("p6_sel_held", mv_sel, 32'd2);
        chk("p6_locked", mv_lock, 32'd0);

        // Period 8 with 3 high / 5 low: duty error, never locks
        do_reset();
        repeat (6) wave(3, 5);
        chk("duty_count", 32'(mv_n), 32'd5);
        chk("duty_err_count", 32'(err_n), 32'd5);
        chk("duty_code", mv_code, 32'd2);
        chk("duty_sel", mv_sel, 32'd2);
        chk("duty_period", mv_per, 32'd8);
        chk("duty_never_locked", 32'(lock_seen), 32'd0);

        // Period 4 lock, then sig_in held low: timeout 40 cycles after last rise
        do_reset();
        repeat (5) wave(2, 2);
        w = cyc;
        wave(2, 2);
        chk("p4_locked", 32'(bus.locked), 32'd1);
        chk("p4_sel", mv_sel, 32'd1);
        m0 = mv_n;
        for (int i = 0; i < 100 && err_n == 0; i++) begin
            bus.sig_in = 1'b0;
            tick();
        end
        chk("to_cycle", 32'(err_cyc), 32'(w + 43));
        chk("to_code", err_seen_code, 32'd3);
        chk("to_locked", 32'(bus.locked), 32'd0);
        chk("to_no_mv", 32'(mv_n), 32'(m0));
        chk("to_sel_held", 32'(bus.sel_out), 32'd1);
        chk("to_period_held", 32'(bus.period_out), 32'd4);
        wave(2, 2);
        chk("to_idle_first_rise", 32'(mv_n), 32'(m0));
        wave(2, 2);
        chk("to_fresh_count", 32'(mv_n), 32'(m0 + 1));
        chk("to_fresh_period", mv_per, 32'd4);
        chk("to_fresh_code", mv_code, 32'd0);

        // Reset pulse mid-period while locked
        do_reset();
        repeat (6) wave(4, 4);
        chk("rst_pre_locked", 32'(bus.locked), 32'd1);
        bus.sig_in = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        bus.sig_in = 1'b0;
        tick();
        rst = 1'b0;
        chk_all_zero("midrst");
        clear_obs();
        wave(0, 3);
        wave(4, 4);
        chk("midrst_no_mv_1st_rise", 32'(mv_n), 32'd0);
        wave(4, 4);
        chk("midrst_mv_2nd_rise", 32'(mv_n), 32'd1);
        chk("midrst_period", mv_per, 32'd8);
        chk("midrst_sel", mv_sel, 32'd2);
        chk("midrst_not_locked", 32'(bus.locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
